// File: rtl/ieee488_hs_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ieee488_hs_ctrl
//  Description : IEEE-488 three-wire handshake (DAV/NRFD/NDAC) sequencer.
//                Acts as source (talk) or acceptor (listen, or whenever ATN
//                is asserted) for one byte at a time, with a byte-stream
//                interface on the inside. All bus pins are active-low and
//                open-collector style: 1 releases the line, 0 pulls it low.
//  Revision    : 1.0 - initial release
// ============================================================================
module ieee488_hs_ctrl #(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    // role select
    input  logic       talk,
    input  logic       listen,
    // transmit stream
    input  logic [7:0] tx_data,
    input  logic       tx_eoi,
    input  logic       tx_valid,
    output logic       tx_ready,
    // receive stream
    output logic [7:0] rx_data,
    output logic       rx_eoi,
    output logic       rx_valid,
    input  logic       rx_ack,
    // sticky errors
    output logic       err_timeout,
    output logic       err_nodev,
    input  logic       err_clr,
    // bus levels (active-low)
    input  logic       atn_i,
    input  logic       dav_i,
    input  logic       nrfd_i,
    input  logic       ndac_i,
    input  logic       eoi_i,
    input  logic [7:0] data_i,
    // bus drives (0 = pull low, 1 = release)
    output logic       dav_o,
    output logic       nrfd_o,
    output logic       ndac_o,
    output logic       eoi_o,
    output logic [7:0] data_o
);

    localparam int            SW        = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);
    localparam logic [SW-1:0] SETTLE_1  = SW'(1);
    localparam logic [9:0]    TMO_LAST  = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        S_WAITRDY  = 3'd1,
        S_SETTLE   = 3'd2,
        S_WAITACC  = 3'd3,
        S_WAITNDAC = 3'd4,
        A_IDLE     = 3'd5,
        A_WAITDAV  = 3'd6,
        A_WAITEND  = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic          listen_q, listen_d;       // acceptor entered through the listen role
    logic [SW-1:0] settle_q, settle_d;
    logic [9:0]    tmo_q, tmo_d;
    logic          dav_q, dav_d;
    logic          nrfd_q, nrfd_d;
    logic          ndac_q, ndac_d;
    logic          eoi_q, eoi_d;
    logic [7:0]    data_q, data_d;
    logic          tx_ready_q, tx_ready_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_eoi_q, rx_eoi_d;
    logic          rx_valid_q, rx_valid_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_nodev_q, err_nodev_d;

    logic          rel;          // release every bus line this tick
    logic          tmo_count;    // current state is a timed wait
    logic          to_set;
    logic          nodev_set;
    logic          in_source;

    // Next-state, bus drive and flag computation for both handshake roles
    always_comb begin
        state_d       = state_q;
        listen_d      = listen_q;
        settle_d      = settle_q;
        dav_d         = dav_q;
        nrfd_d        = nrfd_q;
        ndac_d        = ndac_q;
        eoi_d         = eoi_q;
        data_d        = data_q;
        tx_ready_d    = 1'b0;
        rx_data_d     = rx_data_q;
        rx_eoi_d      = rx_eoi_q;
        rx_valid_d    = rx_ack ? 1'b0 : rx_valid_q;
        rel           = 1'b0;
        tmo_count     = 1'b0;
        to_set        = 1'b0;
        nodev_set     = 1'b0;
        in_source     = (state_q == S_WAITRDY) || (state_q == S_SETTLE) ||
                        (state_q == S_WAITACC) || (state_q == S_WAITNDAC);

        case (state_q)
            ST_IDLE: begin
                dav_d  = 1'b1;
                eoi_d  = 1'b1;
                data_d = 8'hFF;
                nrfd_d = 1'b1;
                ndac_d = 1'b1;
                if (!atn_i) begin
                    // ATN forces the acceptor role regardless of selection
                    state_d  = A_IDLE;
                    listen_d = 1'b0;
                    nrfd_d   = 1'b0;
                    ndac_d   = 1'b0;
                end else if (talk) begin
                    if (tx_valid) state_d = S_WAITRDY;
                end else if (listen) begin
                    state_d  = A_IDLE;
                    listen_d = 1'b1;
                    nrfd_d   = 1'b0;
                    ndac_d   = 1'b0;
                end
            end
            S_WAITRDY: begin
                tmo_count = 1'b1;
                if (nrfd_i && ndac_i) begin
                    // nobody holds NDAC: no device on the bus
                    nodev_set = 1'b1;
                    state_d   = ST_IDLE;
                end else if (nrfd_i && !ndac_i) begin
                    data_d   = ~tx_data;
                    eoi_d    = ~tx_eoi;
                    settle_d = SETTLE_LD;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_d = settle_q - SETTLE_1;
                if (settle_q == SETTLE_1) begin
                    dav_d   = 1'b0;
                    state_d = S_WAITACC;
                end
            end
            S_WAITACC: begin
                tmo_count = 1'b1;
                if (ndac_i) begin
                    rel        = 1'b1;
                    tx_ready_d = 1'b1;
                    state_d    = S_WAITNDAC;
                end
            end
            S_WAITNDAC: begin
                tmo_count = 1'b1;
                if (!ndac_i) state_d = ST_IDLE;
            end
            A_IDLE: begin
                if (atn_i && !listen_q) begin
                    rel     = 1'b1;
                    state_d = ST_IDLE;
                end else if (!rx_valid_q || rx_ack) begin
                    // flow control: ready again only once the byte is consumed
                    nrfd_d  = 1'b1;
                    state_d = A_WAITDAV;
                end
            end
            A_WAITDAV: begin
                tmo_count = !atn_i;
                if (atn_i && !listen_q) begin
                    rel     = 1'b1;
                    state_d = ST_IDLE;
                end else if (!dav_i) begin
                    rx_data_d  = ~data_i;
                    rx_eoi_d   = ~eoi_i;
                    rx_valid_d = 1'b1;
                    nrfd_d     = 1'b0;
                    ndac_d     = 1'b1;
                    state_d    = A_WAITEND;
                end
            end
            A_WAITEND: begin
                tmo_count = 1'b1;
                if (dav_i) begin
                    ndac_d  = 1'b0;
                    state_d = A_IDLE;
                end
            end
            default: begin
                rel     = 1'b1;
                state_d = ST_IDLE;
            end
        endcase

        if (in_source && !atn_i) begin
            // controller took the bus: drop the byte without acknowledging it,
            // tx_valid stays pending and is retried after ATN releases
            rel        = 1'b1;
            state_d    = ST_IDLE;
            tx_ready_d = 1'b0;
            nodev_set  = 1'b0;
            tmo_count  = 1'b0;
        end else if (tmo_count && (state_d == state_q) && (tmo_q == TMO_LAST)) begin
            to_set  = 1'b1;
            rel     = 1'b1;
            state_d = ST_IDLE;
        end

        tmo_d = (state_d != state_q) ? 10'd0 :
                tmo_count            ? tmo_q + 10'd1 : 10'd0;

        if (rel) begin
            dav_d  = 1'b1;
            nrfd_d = 1'b1;
            ndac_d = 1'b1;
            eoi_d  = 1'b1;
            data_d = 8'hFF;
        end

        // a new error on the same tick as err_clr takes precedence
        err_timeout_d = (err_timeout_q & ~err_clr) | to_set;
        err_nodev_d   = (err_nodev_q & ~err_clr) | nodev_set;
    end

    // State and registered outputs; everything advances only on ce ticks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            listen_q      <= 1'b0;
            settle_q      <= '0;
            tmo_q         <= 10'd0;
            dav_q         <= 1'b1;
            nrfd_q        <= 1'b1;
            ndac_q        <= 1'b1;
            eoi_q         <= 1'b1;
            data_q        <= 8'hFF;
            tx_ready_q    <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_eoi_q      <= 1'b0;
            rx_valid_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_nodev_q   <= 1'b0;
        end else if (ce) begin
            state_q       <= state_d;
            listen_q      <= listen_d;
            settle_q      <= settle_d;
            tmo_q         <= tmo_d;
            dav_q         <= dav_d;
            nrfd_q        <= nrfd_d;
            ndac_q        <= ndac_d;
            eoi_q         <= eoi_d;
            data_q        <= data_d;
            tx_ready_q    <= tx_ready_d;
            rx_data_q     <= rx_data_d;
            rx_eoi_q      <= rx_eoi_d;
            rx_valid_q    <= rx_valid_d;
            err_timeout_q <= err_timeout_d;
            err_nodev_q   <= err_nodev_d;
        end
    end

    assign dav_o       = dav_q;
    assign nrfd_o      = nrfd_q;
    assign ndac_o      = ndac_q;
    assign eoi_o       = eoi_q;
    assign data_o      = data_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_eoi      = rx_eoi_q;
    assign rx_valid    = rx_valid_q;
    assign err_timeout = err_timeout_q;
    assign err_nodev   = err_nodev_q;

endmodule
`default_nettype wire

// File: tb/tb_ieee488_hs_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ieee488_hs_ctrl
//  Description : Directed, table-driven bench for ieee488_hs_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ieee488_hs_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce, talk, listen;
    logic [7:0] tx_data;
    logic       tx_eoi, tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_eoi, rx_valid, rx_ack;
    logic       err_timeout, err_nodev, err_clr;
    logic       atn_i, dav_i, nrfd_i, ndac_i, eoi_i;
    logic [7:0] data_i;
    logic       dav_o, nrfd_o, ndac_o, eoi_o;
    logic [7:0] data_o;

    int n_pass  = 0;
    int n_total = 0;
    int txr_cnt = 0;

    always #5 clk = ~clk;

    ieee488_hs_ctrl #(.SETTLE(2), .TIMEOUT(1023)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .talk(talk), .listen(listen),
        .tx_data(tx_data), .tx_eoi(tx_eoi), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_eoi(rx_eoi), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .err_timeout(err_timeout), .err_nodev(err_nodev), .err_clr(err_clr),
        .atn_i(atn_i), .dav_i(dav_i), .nrfd_i(nrfd_i), .ndac_i(ndac_i), .eoi_i(eoi_i),
        .data_i(data_i), .dav_o(dav_o), .nrfd_o(nrfd_o), .ndac_o(ndac_o),
        .eoi_o(eoi_o), .data_o(data_o)
    );

    // {dav,nrfd,ndac,eoi,data,tx_ready,rx_valid,rx_data,rx_eoi}
    typedef struct packed {
        logic        ce, talk, listen, atn, nrfd, ndac, dav, eoi;
        logic [7:0]  dat;
        logic        txv, ack;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic c, input logic tk, input logic ls,
                                input logic atn, input logic nrfd, input logic ndac,
                                input logic dav, input logic eoi, input logic [7:0] dat,
                                input logic txv, input logic ack, input logic [22:0] exp);
        vec_t v;
        v.ce = c; v.talk = tk; v.listen = ls; v.atn = atn; v.nrfd = nrfd;
        v.ndac = ndac; v.dav = dav; v.eoi = eoi; v.dat = dat; v.txv = txv;
        v.ack = ack; v.exp = exp;
        return v;
    endfunction

    function automatic logic [22:0] outs();
        return {dav_o, nrfd_o, ndac_o, eoi_o, data_o, tx_ready, rx_valid, rx_data, rx_eoi};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (tx_ready === 1'b1) txr_cnt++;
    endtask

    task automatic idle_inputs();
        ce = 1'b1; talk = 1'b0; listen = 1'b0; tx_data = 8'h00; tx_eoi = 1'b0;
        tx_valid = 1'b0; rx_ack = 1'b0; err_clr = 1'b0; atn_i = 1'b1; dav_i = 1'b1;
        nrfd_i = 1'b1; ndac_i = 1'b1; eoi_i = 1'b1; data_i = 8'hFF;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        txr_cnt = 0;
    endtask

    initial begin
        // talk 0x41 with a model listener, then listen for 0x0D with EOI
        tbl[0]  = mk(1,1,0,1, 1,0, 1,1,8'hFF, 1,0, {4'b1111,8'hFF,2'b00,8'h00,1'b0});
        tbl[1]  = mk(1,1,0,1, 1,0, 1,1,8'hFF, 1,0, {4'b1111,8'hBE,2'b00,8'h00,1'b0});
        tbl[2]  = mk(1,1,0,1, 1,0, 1,1,8'hFF, 1,0, {4'b1111,8'hBE,2'b00,8'h00,1'b0});
        tbl[3]  = mk(0,1,0,1, 1,0, 1,1,8'hFF, 1,0, {4'b1111,8'hBE,2'b00,8'h00,1'b0});
        tbl[4]  = mk(1,1,0,1, 1,0, 1,1,8'hFF, 1,0, {4'b0111,8'hBE,2'b00,8'h00,1'b0});
        tbl[5]  = mk(1,1,0,1, 0,0, 1,1,8'hFF, 1,0, {4'b0111,8'hBE,2'b00,8'h00,1'b0});
        tbl[6]  = mk(1,1,0,1, 0,1, 1,1,8'hFF, 1,0, {4'b1111,8'hFF,2'b10,8'h00,1'b0});
        tbl[7]  = mk(1,1,0,1, 0,1, 1,1,8'hFF, 0,0, {4'b1111,8'hFF,2'b00,8'h00,1'b0});
        tbl[8]  = mk(1,1,0,1, 0,0, 1,1,8'hFF, 0,0, {4'b1111,8'hFF,2'b00,8'h00,1'b0});
        tbl[9]  = mk(1,0,1,1, 1,1, 1,1,8'hFF, 0,0, {4'b1001,8'hFF,2'b00,8'h00,1'b0});
        tbl[10] = mk(1,0,1,1, 1,1, 1,1,8'hFF, 0,0, {4'b1101,8'hFF,2'b00,8'h00,1'b0});
        tbl[11] = mk(1,0,1,1, 1,1, 1,1,8'hFF, 0,0, {4'b1101,8'hFF,2'b00,8'h00,1'b0});
        tbl[12] = mk(1,0,1,1, 1,1, 0,0,8'hF2, 0,0, {4'b1011,8'hFF,2'b01,8'h0D,1'b1});
        tbl[13] = mk(1,0,1,1, 1,1, 0,0,8'hF2, 0,0, {4'b1011,8'hFF,2'b01,8'h0D,1'b1});
        tbl[14] = mk(1,0,1,1, 1,1, 1,1,8'hFF, 0,0, {4'b1001,8'hFF,2'b01,8'h0D,1'b1});
        tbl[15] = mk(1,0,1,1, 1,1, 1,1,8'hFF, 0,0, {4'b1001,8'hFF,2'b01,8'h0D,1'b1});
        tbl[16] = mk(1,0,1,1, 1,1, 1,1,8'hFF, 0,1, {4'b1101,8'hFF,2'b00,8'h0D,1'b1});
        tbl[17] = mk(1,0,1,1, 1,1, 1,1,8'hFF, 0,0, {4'b1101,8'hFF,2'b00,8'h0D,1'b1});
        tbl[18] = mk(1,0,1,1, 1,1, 1,1,8'hFF, 0,0, {4'b1101,8'hFF,2'b00,8'h0D,1'b1});

        // ---------------- reset state ----------------
        do_reset();
        #1;
        check("reset_outs", {9'd0, outs()}, {9'd0, 4'b1111, 8'hFF, 2'b00, 8'h00, 1'b0});
        check("reset_errs", {30'd0, err_timeout, err_nodev}, 32'd0);

        // ---------------- table: talk 0x41 then listen 0x0D ----------------
        tx_data = 8'h41;
        tx_eoi  = 1'b0;
        for (int i = 0; i < 19; i++) begin
            ce = tbl[i].ce; talk = tbl[i].talk; listen = tbl[i].listen;
            atn_i = tbl[i].atn; nrfd_i = tbl[i].nrfd; ndac_i = tbl[i].ndac;
            dav_i = tbl[i].dav; eoi_i = tbl[i].eoi; data_i = tbl[i].dat;
            tx_valid = tbl[i].txv; rx_ack = tbl[i].ack;
            tick();
            check($sformatf("vec%0d", i), {9'd0, outs()}, {9'd0, tbl[i].exp});
        end
        check("talk_txready_once", txr_cnt, 1);

        // ---------------- no device ----------------
        do_reset();
        talk = 1'b1; tx_valid = 1'b1; tx_data = 8'h41; nrfd_i = 1'b1; ndac_i = 1'b1;
        tick();
        tick();
        check("nodev_set", {30'd0, err_nodev, dav_o}, 32'd3);
        err_clr = 1'b1;
        tick();
        check("nodev_clr", {31'd0, err_nodev}, 32'd0);
        tick();
        check("nodev_beats_clr", {30'd0, err_nodev, dav_o}, 32'd3);
        err_clr = 1'b0;
        tx_valid = 1'b0;
        tick();

        // ---------------- ATN during settle, command receive, retry ----------------
        do_reset();
        talk = 1'b1; tx_valid = 1'b1; tx_data = 8'h55; tx_eoi = 1'b1;
        nrfd_i = 1'b1; ndac_i = 1'b0;
        tick();
        tick();
        check("atn_pre_data", {23'd0, eoi_o, data_o}, {23'd0, 1'b0, 8'hAA});
        atn_i = 1'b0;
        tick();
        check("atn_abort", {21'd0, dav_o, eoi_o, data_o, tx_ready}, {21'd0, 1'b1, 1'b1, 8'hFF, 1'b0});
        tick();
        check("atn_acc_idle", {30'd0, nrfd_o, ndac_o}, 32'd0);
        tick();
        check("atn_acc_rdy", {30'd0, nrfd_o, ndac_o}, 32'd2);
        dav_i = 1'b0; data_i = 8'hD7; eoi_i = 1'b1;
        tick();
        check("atn_cmd_rx", {19'd0, rx_valid, rx_eoi, rx_data, nrfd_o, ndac_o, dav_o},
              {19'd0, 1'b1, 1'b0, 8'h28, 1'b0, 1'b1, 1'b1});
        dav_i = 1'b1; data_i = 8'hFF;
        tick();
        rx_ack = 1'b1;
        tick();
        check("atn_ack", {30'd0, rx_valid, nrfd_o}, 32'd1);
        rx_ack = 1'b0; atn_i = 1'b1;
        tick();
        check("atn_release", {29'd0, nrfd_o, ndac_o, dav_o}, 32'd7);
        tick();
        tick();
        tick();
        tick();
        check("retry_dav", {22'd0, dav_o, eoi_o, data_o}, {22'd0, 1'b0, 1'b0, 8'hAA});
        ndac_i = 1'b1;
        tick();
        check("retry_txready", {31'd0, tx_ready}, 32'd1);
        check("atn_txready_count", txr_cnt, 1);
        tx_valid = 1'b0;

        // ---------------- timeout in S_WAITACC ----------------
        do_reset();
        talk = 1'b1; tx_valid = 1'b1; tx_data = 8'h41; nrfd_i = 1'b1; ndac_i = 1'b0;
        repeat (4) tick();
        check("tmo_in_waitacc", {31'd0, dav_o}, 32'd0);
        repeat (1022) tick();
        check("tmo_not_yet", {30'd0, err_timeout, dav_o}, 32'd0);
        tick();
        check("tmo_fired", {20'd0, err_timeout, dav_o, nrfd_o, ndac_o, eoi_o, data_o},
              {20'd0, 5'b11111, 8'hFF});
        tx_valid = 1'b0;

        // ---------------- async reset mid-transfer ----------------
        do_reset();
        talk = 1'b1; tx_valid = 1'b1; tx_data = 8'h41; nrfd_i = 1'b1; ndac_i = 1'b0;
        repeat (4) tick();
        check("arst_pre", {31'd0, dav_o}, 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_outs", {9'd0, outs()}, {9'd0, 4'b1111, 8'hFF, 2'b00, 8'h00, 1'b0});
        #2;
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
